// File: rtl/uart_width_conv_fifo.sv
// uart_width_conv_fifo: show-ahead FIFO that accepts wide words and pops them back one lane at a time
module uart_width_conv_fifo #(
    parameter int WR_DATA_WIDTH = 32,
    parameter int RATIO         = 4,
    parameter int DEPTH_WIDTH   = 8,
    parameter int MSB_FIRST     = 1,
    parameter int AFULL_LEVEL   = 240,
    localparam int RD_DATA_WIDTH = WR_DATA_WIDTH / RATIO,
    localparam int LANE_BITS     = $clog2(RATIO)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             wr_en,
    input  logic [WR_DATA_WIDTH-1:0]         wr_data,
    output logic                             wr_vld,
    input  logic                             rd_en,
    output logic                             rd_vld,
    output logic [RD_DATA_WIDTH-1:0]         rd_data,
    output logic [DEPTH_WIDTH:0]             wr_count,
    output logic [DEPTH_WIDTH+LANE_BITS:0]   rd_count,
    output logic                             almost_full,
    output logic                             overflow,
    output logic                             underflow
);
    localparam int LW    = (RATIO > 1) ? LANE_BITS : 1;
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int CW    = DEPTH_WIDTH + 1;
    localparam int RCW   = CW + LANE_BITS;

    logic [WR_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_WIDTH-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]            r_count;
    logic [LW-1:0]            r_lane;
    logic [RCW-1:0]           r_rd_count;
    logic                     r_wr_vld, r_rd_vld, r_afull, r_ovf, r_udf;
    logic                     w_wr, w_pop, w_last, w_pop_word;
    logic [CW-1:0]            w_count_nx;
    logic [LW-1:0]            w_lane_nx, w_idx;
    logic [WR_DATA_WIDTH-1:0] w_head, w_shifted;

    // flush masks both accepts so the discarded write/read never touches state
    always_comb begin
        w_wr       = wr_en & r_wr_vld & ~flush;
        w_pop      = rd_en & r_rd_vld & ~flush;
        w_last     = r_lane == LW'(RATIO - 1);
        w_pop_word = w_pop & w_last;
        w_count_nx = flush ? '0 : r_count + CW'(w_wr) - CW'(w_pop_word);
        w_lane_nx  = (flush || w_pop_word) ? '0 : w_pop ? r_lane + 1'b1 : r_lane;
        w_idx      = (MSB_FIRST != 0) ? LW'(RATIO - 1) - r_lane : r_lane;
        w_head     = r_mem[r_rptr];
        w_shifted  = w_head >> (w_idx * RD_DATA_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wr_data;
    end

    // ready/valid flags come from the next count, so a full FIFO never bypasses a write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_lane     <= '0;
            r_rd_count <= '0;
            r_wr_vld   <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_afull    <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_wptr     <= flush ? '0 : r_wptr + DEPTH_WIDTH'(w_wr);
            r_rptr     <= flush ? '0 : r_rptr + DEPTH_WIDTH'(w_pop_word);
            r_count    <= w_count_nx;
            r_lane     <= w_lane_nx;
            r_rd_count <= (RCW'(w_count_nx) << LANE_BITS) - RCW'(w_lane_nx);
            r_wr_vld   <= ~w_count_nx[DEPTH_WIDTH];
            r_rd_vld   <= w_count_nx != '0;
            r_afull    <= w_count_nx >= CW'(AFULL_LEVEL);
            r_ovf      <= r_ovf | (wr_en & ~r_wr_vld);
            r_udf      <= r_udf | (rd_en & ~r_rd_vld);
        end
    end

    assign wr_vld      = r_wr_vld;
    assign rd_vld      = r_rd_vld;
    assign rd_data     = r_rd_vld ? w_shifted[RD_DATA_WIDTH-1:0] : '0;
    assign wr_count    = r_count;
    assign rd_count    = r_rd_count;
    assign almost_full = r_afull;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;
endmodule

// File: tb/tb_uart_width_conv_fifo.sv
// tb_uart_width_conv_fifo: queue-model bench for MSB-first and LSB-first instances on shared stimulus
module tb_uart_width_conv_fifo;
    logic        clk = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0;
    logic [31:0] wr_data = 0;
    logic        wr_vld, rd_vld, almost_full, overflow, underflow;
    logic [7:0]  rd_data;
    logic [8:0]  wr_count;
    logic [10:0] rd_count;
    logic        l_wr_vld, l_rd_vld, l_almost_full, l_overflow, l_underflow;
    logic [7:0]  l_rd_data;
    logic [8:0]  l_wr_count;
    logic [10:0] l_rd_count;

    uart_width_conv_fifo u_dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .wr_vld(wr_vld),
        .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data), .wr_count(wr_count), .rd_count(rd_count),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    uart_width_conv_fifo #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .wr_vld(l_wr_vld),
        .rd_en(rd_en), .rd_vld(l_rd_vld), .rd_data(l_rd_data), .wr_count(l_wr_count), .rd_count(l_rd_count),
        .almost_full(l_almost_full), .overflow(l_overflow), .underflow(l_underflow)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] q[$];
    int          lane = 0;
    bit          m_wvld = 0, m_rvld = 0, m_ovf = 0, m_udf = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lane_of(input bit msb);
        if (!m_rvld || q.size() == 0) return 8'h00;
        return 8'(q[0] >> (8 * (msb ? 3 - lane : lane)));
    endfunction

    task automatic model_step;
        bit acc, pop;
        if (rst) begin
            q.delete();
            lane = 0; m_wvld = 0; m_rvld = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        acc = wr_en && m_wvld;
        pop = rd_en && m_rvld;
        if (wr_en && !m_wvld) m_ovf = 1;
        if (rd_en && !m_rvld) m_udf = 1;
        if (flush) begin
            q.delete();
            lane = 0;
        end else begin
            if (pop) begin
                if (lane == 3) begin
                    void'(q.pop_front());
                    lane = 0;
                end else lane++;
            end
            if (acc) q.push_back(wr_data);
        end
        m_wvld = q.size() < 256;
        m_rvld = q.size() != 0;
    endtask

    task automatic check_all;
        chk("wr_vld", wr_vld, m_wvld);
        chk("rd_vld", rd_vld, m_rvld);
        chk("rd_data", rd_data, lane_of(1));
        chk("wr_count", wr_count, q.size());
        chk("rd_count", rd_count, q.size() * 4 - lane);
        chk("almost_full", almost_full, q.size() >= 240);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
        chk("lsb_rd_data", l_rd_data, lane_of(0));
        chk("lsb_rd_count", l_rd_count, q.size() * 4 - lane);
    endtask

    task automatic cycle;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [7:0] exp_m [4];
        logic [7:0] exp_l [4];
        int mode;
        exp_m = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_l = '{8'h44, 8'h33, 8'h22, 8'h11};
        idle(2);
        chk("reset_wr_vld", wr_vld, 0);
        chk("reset_rd_count", rd_count, 0);
        rst = 0;
        cycle();
        chk("post_reset_wr_vld", wr_vld, 1);

        wr_en = 1; wr_data = 32'h11223344;
        cycle();
        wr_en = 0; rd_en = 1;
        chk("first_rd_vld", rd_vld, 1);
        for (int i = 0; i < 4; i++) begin
            chk("msb_lane", rd_data, exp_m[i]);
            chk("lsb_lane", l_rd_data, exp_l[i]);
            chk("lane_rd_count", rd_count, 4 - i);
            cycle();
        end
        rd_en = 0;
        chk("empty_after_4", rd_vld, 0);
        chk("empty_rd_count", rd_count, 0);

        rd_en = 1;
        cycle();
        rd_en = 0;
        chk("underflow_set", underflow, 1);
        chk("underflow_rd_data", rd_data, 0);
        flush = 1;
        cycle();
        flush = 0;
        chk("underflow_kept", underflow, 1);

        for (int i = 0; i < 256; i++) begin
            wr_en = 1; wr_data = $urandom;
            cycle();
            if (i == 238) chk("afull_239", almost_full, 0);
            if (i == 239) chk("afull_240", almost_full, 1);
        end
        chk("full_wr_vld", wr_vld, 0);
        cycle();
        wr_en = 0;
        chk("overflow_set", overflow, 1);
        chk("full_wr_count", wr_count, 256);

        rd_en = 1;
        idle(3);
        chk("no_bypass", wr_vld, 0);
        cycle();
        chk("wr_vld_rise", wr_vld, 1);
        idle(1020);
        rd_en = 0;
        chk("drained", rd_vld, 0);

        wr_en = 1; wr_data = 32'h01020304;
        cycle();
        wr_en = 0; rd_en = 1;
        idle(3);
        wr_en = 1; wr_data = 32'hC0FFEE55;
        cycle();
        wr_en = 0;
        chk("simul_wr_count", wr_count, 1);
        chk("simul_rd_vld", rd_vld, 1);
        chk("simul_new_lane0", rd_data, 8'hC0);
        idle(4);
        rd_en = 0;

        wr_en = 1;
        for (int i = 0; i < 5; i++) begin
            wr_data = $urandom;
            cycle();
        end
        wr_en = 0; rd_en = 1;
        idle(2);
        rd_en = 0; rst = 1;
        cycle();
        rst = 0;
        chk("rst_wr_vld", wr_vld, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        cycle();
        wr_en = 1; wr_data = 32'hAABBCCDD;
        cycle();
        wr_en = 0;
        chk("after_rst_head", rd_data, 8'hAA);

        for (int i = 0; i < 4000; i++) begin
            mode = (i / 500) % 3;
            wr_en   = $urandom_range(0, 99) < (mode == 0 ? 85 : mode == 1 ? 15 : 50);
            rd_en   = $urandom_range(0, 99) < (mode == 0 ? 20 : mode == 1 ? 90 : 50);
            flush   = $urandom_range(0, 299) == 0;
            rst     = $urandom_range(0, 999) == 0;
            wr_data = $urandom;
            cycle();
        end
        rst = 0; flush = 0; wr_en = 0; rd_en = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_width_conv_fifo.md
UART_WIDTH_CONV_FIFO -- requirements
Module: uart_width_conv_fifo

Interface
REQ-001 The block SHALL take parameter WR_DATA_WIDTH, default 32, meaning the write word width in bits.
REQ-002 The block SHALL take parameter RATIO, default 4, meaning read lanes per write word; legal values are 1, 2, 4 and 8, and RATIO SHALL divide WR_DATA_WIDTH.
REQ-003 The block SHALL take parameter DEPTH_WIDTH, default 8, meaning log2 of the storage depth in write words (DEPTH = 2^DEPTH_WIDTH).
REQ-004 The block SHALL take parameter MSB_FIRST, default 1, meaning 1 = most-significant lane is read first and 0 = least-significant lane is read first.
REQ-005 The block SHALL take parameter AFULL_LEVEL, default 240, meaning the stored-word threshold for almost_full.
REQ-006 The read width RD_DATA_WIDTH SHALL be WR_DATA_WIDTH/RATIO.
REQ-007 The block SHALL have these ports (one per line: name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  WR_DATA_WIDTH  write word.
- wr_vld  out  1  space available (write ready).
- rd_en  in  1  read (lane pop) request.
- rd_vld  out  1  rd_data holds a valid lane (show-ahead).
- rd_data  out  RD_DATA_WIDTH  current head lane.
- wr_count  out  DEPTH_WIDTH+1  words stored.
- rd_count  out  DEPTH_WIDTH+1+log2(RATIO)  lanes available.
- almost_full  out  1  wr_count >= AFULL_LEVEL.
- overflow  out  1  sticky: write attempted while wr_vld=0.
- underflow  out  1  sticky: read attempted while rd_vld=0.

Function
REQ-008 The block SHALL store words in a DEPTH x WR_DATA_WIDTH array with a write pointer, a read pointer, a word count, and a lane counter (0..RATIO-1).
REQ-009 A write SHALL be accepted when wr_en=1 and wr_vld=1; wr_data SHALL be stored at the write pointer, and the pointer SHALL increment modulo DEPTH.
REQ-010 wr_en=1 with wr_vld=0 SHALL leave the contents unchanged and set overflow.
REQ-011 wr_vld and rd_vld SHALL be registered, computed from the next-cycle count: wr_vld = (next count < DEPTH); rd_vld = (next count != 0).
REQ-012 Write-to-read latency SHALL be 1 cycle: a word accepted into an empty FIFO in cycle N gives rd_vld=1 in cycle N+1.
REQ-013 rd_data SHALL be the head word's lane selected by the lane counter, show-ahead, with no rd_en needed to present it.
REQ-014 Lane k SHALL be bits [W-1-k*R : W-(k+1)*R] when MSB_FIRST=1, and bits [(k+1)*R-1 : k*R] when MSB_FIRST=0.
REQ-015 rd_data SHALL be 0 whenever rd_vld=0.
REQ-016 A pop SHALL occur on rd_en=1 with rd_vld=1: if lane < RATIO-1, the lane SHALL increment; otherwise the lane SHALL go to 0, the read pointer SHALL increment modulo DEPTH, and the count SHALL decrement.
REQ-017 rd_en=1 with rd_vld=0 SHALL set underflow, and the lane counter SHALL stay unchanged.
REQ-018 A simultaneous accepted write and last-lane pop SHALL leave the count unchanged; both pointers SHALL advance.
REQ-019 There SHALL be no write bypass when full: wr_vld stays 0 even in a cycle where the last lane is popped, and wr_vld rises the following cycle.
REQ-020 rd_count SHALL equal wr_count*RATIO - lane.
REQ-021 wr_count, rd_count and almost_full SHALL be registered and consistent with the count in the same cycle.
REQ-022 flush=1 SHALL zero the pointers, count and lane next cycle, with wr_vld=1 and rd_vld=0; overflow and underflow SHALL be unaffected.
REQ-023 flush SHALL take priority over a simultaneous write or read in the same cycle, and that write or read SHALL be discarded.
REQ-024 With RATIO=1 the block SHALL behave as a plain show-ahead FIFO, with the lane counter held at 0.

Reset
REQ-025 rst=1 SHALL, at the next edge, zero the pointers, count, lane, overflow and underflow, and set wr_vld=0, rd_vld=0, rd_data=0, wr_count=0, rd_count=0 and almost_full=0.
REQ-026 The first cycle after rst falls SHALL show wr_vld=1.
REQ-027 rst SHALL override flush, wr_en and rd_en.
REQ-028 Array contents need not be cleared by rst, but stale data SHALL never be presented on rd_data.

Verification
REQ-029 The bench SHALL cover: defaults, write 0x11223344, then hold rd_en -> rd_vld=1 next cycle; rd_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles; rd_vld=0 after the 4th pop; rd_count 4, 3, 2, 1, 0.
REQ-030 The bench SHALL cover: MSB_FIRST=0, same stimulus -> rd_data 0x44, 0x33, 0x22, 0x11.
REQ-031 The bench SHALL cover: 256 back-to-back writes -> almost_full=1 once wr_count=240; wr_vld=0 after the 256th acceptance; a 257th wr_en sets overflow=1 with wr_count=256.
REQ-032 The bench SHALL cover: count=1, lane=3, a write and rd_en in the same cycle -> wr_count stays 1, rd_vld stays 1, and the new word's lane 0 appears next cycle.
REQ-033 The bench SHALL cover: 5 words stored, lane=2, then assert rst one cycle -> next cycle all outputs at reset values; after release, a single write 0xAABBCCDD reads back 0xAA first.
REQ-034 The bench SHALL cover: empty FIFO, rd_en=1 -> underflow=1, lane=0, rd_data=0; then flush -> underflow stays 1.
